multicycle_decode: RTL
======================

Name: multicycle_decode

Overview:
- Multicycle successor to the single-cycle decoder; it drives the multicycle datapath of the ARM-subset core.
- A main FSM sequences fetch, decode, execute and writeback over several cycles.
- Multiply is iterative and takes a parameterised number of cycles. Long multiply writes back in two phases.
- FPU ops use a start/done handshake with a bounded timeout.
- All conditional execution is resolved in DECODE.

Parameters:
- MUL_CYCLES, 4: cycles spent in MULEX per multiply. Legal range 1..15.
- FPU_TIMEOUT, 16: max cycles waiting for fpu_done before aborting to FETCH. Legal range 2..255.
- STATE_W, 4: state register width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]
- Rd  in  4  instr[15:12]
- MulOp  in  4  instr[7:4]; 4'b1001 marks multiply
- CondEx  in  1  condition passed (from the condition unit, valid in DECODE)
- fpu_done  in  1  FPU result valid, single-cycle pulse
- PCWrite  out  1  PC write enable
- AdrSrc  out  1  0 = PC, 1 = ALUResult as memory address
- IRWrite  out  1  instruction register load
- MemW  out  1  data memory write
- RegW  out  1  register file write
- MulWrite  out  1  high-half register write (long multiply)
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 = Rm, 01 = ExtImm, 10 = const 4
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = FPUResult
- ImmSrc  out  2  00 = imm8, 01 = imm12, 10 = imm24
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UMULL, 110 SMULL
- FPUControl  out  2  Funct[2:1]
- FlagW  out  2  ALU flag write enables, [1] = NZ, [0] = CV
- FPUFlagW  out  2  FPU flag write enables
- fpu_start  out  1  single-cycle pulse launching an FPU op
- busy  out  1  high in every state except FETCH
- fpu_abort  out  1  single-cycle pulse on FPU timeout

Behaviour:
- Reset (async): state = FETCH; mul_cnt = 0; fpu_cnt = 0. On the first edge after deassertion the FSM performs FETCH.
- Defaults: every output is 0 unless asserted by the current state.
- Outputs are Moore, decoded from state. Exception: ALUControl, FlagW, FPUControl and FPUFlagW also depend on the latched instruction fields.
- Class decode, combinational, used in DECODE:
  - DP: Op = 00 and not multiply.
  - MUL: Op = 00, Funct[5] = 0 and MulOp = 1001.
  - MEM: Op = 01; load when Funct[0] = 1.
  - BR: Op = 10.
  - FPU: Op = 11.
- States and actions:
  - FETCH: IRWrite, PCWrite, ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10, AdrSrc = 0. Next state DECODE.
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10. ImmSrc = Op.
    - If !CondEx, go to FETCH; the instruction is squashed with no writes.
    - Otherwise dispatch: MEM -> MEMADR; DP with Funct[5] -> EXECI; DP with !Funct[5] -> EXECR; MUL -> MULEX; BR -> BRANCH; FPU -> FPUREQ.
  - EXECR / EXECI: ALUSrcB = 00 or 01 respectively. ALU decode per Funct[4:1]:
    - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
    - Any other code: ALUControl = 000 and WB is forced to no write (treated as NOP).
    - FlagW[1] = Funct[0]; FlagW[0] = Funct[0] & (ADD | SUB).
    - Next state ALUWB.
  - ALUWB: RegW = 1, ResultSrc = 00. If Rd = 15, also PCWrite.
    - Compare ops (Funct[4:1] = 1010) skip the write. Next state FETCH.
  - MULEX: ALUControl from Funct[3:1]: 000 MUL, 100 UMULL, 110 SMULL; any other value is a NOP and returns to FETCH.
    - mul_cnt increments each cycle. Exit when mul_cnt == MUL_CYCLES-1, then mul_cnt = 0 and go to MULWB.
    - FlagW[1] = Funct[0] on the exit cycle only. FlagW[0] is never set.
  - MULWB: RegW = 1. Next state FETCH for MUL, MULWBHI for UMULL/SMULL.
  - MULWBHI: MulWrite = 1, RegW = 0. Next state FETCH.
  - MEMADR: ALUSrcB = 01, ALUControl = ADD. Next state MEMRD for a load, MEMWR for a store.
  - MEMRD: AdrSrc = 1. Next state MEMWB.
  - MEMWB: RegW = 1, ResultSrc = 01. If Rd = 15, also PCWrite. Next state FETCH.
  - MEMWR: AdrSrc = 1, MemW = 1. Next state FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 01, ResultSrc = 10, PCWrite. Next state FETCH.
  - FPUREQ: fpu_start = 1, fpu_cnt = 0. Next state FPUWAIT.
  - FPUWAIT: fpu_cnt increments each cycle.
    - If fpu_done: go to FPUWB.
    - Else if fpu_cnt == FPU_TIMEOUT-1: pulse fpu_abort and go to FETCH with no write.
    - fpu_done arriving on the timeout cycle wins.
  - FPUWB: RegW = 1, ResultSrc = 11, FPUFlagW[1] = Funct[0], FPUFlagW[0] = 0. Next state FETCH.
  - fpu_done seen outside FPUWAIT is ignored.
- Latency per instruction, counted FETCH to FETCH:
  - DP: 4 cycles. Store: 4. Load: 5. Branch: 3.
  - MUL: 3 + MUL_CYCLES. Long multiply: 4 + MUL_CYCLES.
  - FPU: 4 + wait cycles.
- Reset asserted mid-instruction returns to FETCH immediately. No partial writeback occurs and the counters clear.
- Encodings outside the legal state set go to FETCH.

Decomposition:
- Package decode_pkg holds:
  - State enum localparams.
  - ALUControl codes.
  - ResultSrc and ALUSrcB codes.
  - Op class codes.
  - The MULOP_PATTERN constant (4'b1001).
- One natural sub-module, decode_ctrl (combinational): ALU/FPU/multiply field decode and flag-enable logic.
- The FSM and both counters stay in the top module.

Test Plan:
- ADD with S bit (Op = 00, Funct = 001001), CondEx = 1 -> FETCH, DECODE, EXECR, ALUWB. Checks: ALUControl = 000 and FlagW = 11 in EXECR; RegW in ALUWB; back in FETCH on cycle 5.
- UMULL, MUL_CYCLES = 4 (Op = 00, Funct = 001000, MulOp = 1001) -> 4 MULEX cycles with ALUControl = 101. Then MULWB with RegW = 1, then MULWBHI with MulWrite = 1 and RegW = 0. Total 8 cycles.
- LDR to Rd = 15 (Op = 01, Funct[0] = 1) -> MEMRD with AdrSrc = 1, then MEMWB with RegW = 1, ResultSrc = 01 and PCWrite = 1.
- FPU op (Op = 11, Funct = 000101) with fpu_done asserted 3 cycles after fpu_start -> FPUWB with FPUControl = 10, FPUFlagW = 10, RegW = 1. Second case: fpu_done never arrives, FPU_TIMEOUT = 16 -> fpu_abort pulses once, no RegW, state returns to FETCH.
- CondEx = 0 on a STR -> DECODE then FETCH; MemW is never asserted.
- Reset asserted in the 2nd MULEX cycle -> all outputs 0 asynchronously. After release: FETCH, mul_cnt = 0, and the next MUL takes the full MUL_CYCLES.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared state, ALU, mux-select and instruction-class encodings for the multicycle decoder
package decode_pkg;
  localparam int STATE_BITS = 4;
  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB, S_MULEX, S_MULWB, S_MULWBHI,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_FPUREQ, S_FPUWAIT, S_FPUWB
  } state_t;
  typedef enum logic [2:0] {C_DP, C_MUL, C_MEM, C_BR, C_FPU} cls_t;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_MUL   = 3'b100;
  localparam logic [2:0] ALU_UMULL = 3'b101;
  localparam logic [2:0] ALU_SMULL = 3'b110;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_FPU    = 2'b11;
  localparam logic [1:0] SRCB_RM  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;
  localparam logic [3:0] MULOP_PATTERN = 4'b1001;
endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational instruction-class, ALU/multiply/FPU field and flag-enable decode
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] mul_op,
  output cls_t       cls,
  output logic [2:0] alu_ctrl,
  output logic [1:0] alu_flagw,
  output logic       alu_wr,
  output logic [2:0] mul_ctrl,
  output logic       mul_ok,
  output logic       mul_long,
  output logic [1:0] mul_flagw,
  output logic [1:0] fpu_ctrl,
  output logic [1:0] fpu_flagw
);
  logic is_add, is_sub, is_and, is_orr;
  always_comb begin
    is_add = funct[4:1] == 4'b0100;
    is_sub = funct[4:1] == 4'b0010;
    is_and = funct[4:1] == 4'b0000;
    is_orr = funct[4:1] == 4'b1100;
    cls = op == 2'b01 ? C_MEM : op == 2'b10 ? C_BR : op == 2'b11 ? C_FPU :
          (!funct[5] && mul_op == MULOP_PATTERN) ? C_MUL : C_DP;
    alu_ctrl = is_sub ? ALU_SUB : is_and ? ALU_AND : is_orr ? ALU_ORR : ALU_ADD;
    alu_flagw = {funct[0], funct[0] & (is_add | is_sub)};
    alu_wr = is_add | is_sub | is_and | is_orr;
    mul_ctrl = funct[3:1] == 3'b000 ? ALU_MUL : funct[3:1] == 3'b100 ? ALU_UMULL :
               funct[3:1] == 3'b110 ? ALU_SMULL : ALU_ADD;
    mul_ok = funct[3:1] inside {3'b000, 3'b100, 3'b110};
    mul_long = funct[3];
    mul_flagw = {funct[0] & mul_ok, 1'b0};
    fpu_ctrl = funct[2:1];
    fpu_flagw = {funct[0], 1'b0};
  end
endmodule

// File: rtl/multicycle_decode.sv
// multicycle_decode: main FSM sequencing fetch/decode/execute/writeback for the multicycle ARM-subset datapath
module multicycle_decode
  import decode_pkg::*;
#(
  parameter int MUL_CYCLES  = 4,
  parameter int FPU_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] MulOp,
  input  logic       CondEx,
  input  logic       fpu_done,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemW,
  output logic       RegW,
  output logic       MulWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [1:0] FPUControl,
  output logic [1:0] FlagW,
  output logic [1:0] FPUFlagW,
  output logic       fpu_start,
  output logic       busy,
  output logic       fpu_abort
);
  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic [7:0] fpu_cnt_q, fpu_cnt_d;
  logic mul_last, fpu_last;
  cls_t cls;
  logic [2:0] alu_ctrl, mul_ctrl;
  logic [1:0] alu_flagw, mul_flagw, fpu_ctrl, fpu_flagw;
  logic alu_wr, mul_ok, mul_long;

  decode_ctrl u_ctrl (
    .op(Op), .funct(Funct), .mul_op(MulOp), .cls(cls),
    .alu_ctrl(alu_ctrl), .alu_flagw(alu_flagw), .alu_wr(alu_wr),
    .mul_ctrl(mul_ctrl), .mul_ok(mul_ok), .mul_long(mul_long), .mul_flagw(mul_flagw),
    .fpu_ctrl(fpu_ctrl), .fpu_flagw(fpu_flagw)
  );

  always_comb begin
    mul_last = mul_cnt_q == 4'(MUL_CYCLES - 1);
    fpu_last = fpu_cnt_q == 8'(FPU_TIMEOUT - 1);
    state_d = S_FETCH;
    mul_cnt_d = '0;
    fpu_cnt_d = '0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = !CondEx ? S_FETCH : cls == C_MEM ? S_MEMADR : cls == C_BR ? S_BRANCH :
                          cls == C_FPU ? S_FPUREQ : cls == C_MUL ? S_MULEX :
                          Funct[5] ? S_EXECI : S_EXECR;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MULEX: begin
        state_d = !mul_ok ? S_FETCH : mul_last ? S_MULWB : S_MULEX;
        mul_cnt_d = (mul_ok && !mul_last) ? mul_cnt_q + 4'd1 : '0;
      end
      S_MULWB:   state_d = mul_long ? S_MULWBHI : S_FETCH;
      S_MEMADR:  state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_FPUREQ:  state_d = S_FPUWAIT;
      S_FPUWAIT: begin
        state_d = fpu_done ? S_FPUWB : fpu_last ? S_FETCH : S_FPUWAIT;
        fpu_cnt_d = (fpu_done || fpu_last) ? '0 : fpu_cnt_q + 8'd1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    {PCWrite, AdrSrc, IRWrite, MemW, RegW, MulWrite, ALUSrcA, fpu_start, busy, fpu_abort} = '0;
    {ALUSrcB, ResultSrc, ImmSrc, FPUControl, FlagW, FPUFlagW} = '0;
    ALUControl = ALU_ADD;
    if (!reset) begin
      busy = state_q != S_FETCH;
      case (state_q)
        S_FETCH:  {IRWrite, PCWrite, ALUSrcA, ALUSrcB, ResultSrc} = {3'b111, SRCB_4, RES_ALURES};
        S_DECODE: {ALUSrcA, ALUSrcB, ResultSrc, ImmSrc} = {1'b1, SRCB_4, RES_ALURES, Op};
        S_EXECR, S_EXECI: begin
          ALUSrcB = state_q == S_EXECI ? SRCB_IMM : SRCB_RM;
          ALUControl = alu_ctrl;
          FlagW = alu_flagw;
        end
        S_ALUWB: begin
          RegW = alu_wr;
          PCWrite = alu_wr && Rd == 4'd15;
          ResultSrc = RES_ALUOUT;
        end
        S_MULEX: begin
          ALUControl = mul_ctrl;
          FlagW = mul_last ? mul_flagw : '0;
        end
        S_MULWB:   RegW = 1'b1;
        S_MULWBHI: MulWrite = 1'b1;
        S_MEMADR:  {ALUSrcB, ALUControl} = {SRCB_IMM, ALU_ADD};
        S_MEMRD:   AdrSrc = 1'b1;
        S_MEMWB:   {RegW, ResultSrc, PCWrite} = {1'b1, RES_DATA, Rd == 4'd15};
        S_MEMWR:   {AdrSrc, MemW} = 2'b11;
        S_BRANCH:  {ALUSrcA, ALUSrcB, ResultSrc, PCWrite} = {1'b1, SRCB_IMM, RES_ALURES, 1'b1};
        S_FPUREQ:  {fpu_start, FPUControl} = {1'b1, fpu_ctrl};
        S_FPUWAIT: {fpu_abort, FPUControl} = {!fpu_done && fpu_last, fpu_ctrl};
        S_FPUWB:   {RegW, ResultSrc, FPUControl, FPUFlagW} = {1'b1, RES_FPU, fpu_ctrl, fpu_flagw};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_FETCH;
      mul_cnt_q <= '0;
      fpu_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mul_cnt_q <= mul_cnt_d;
      fpu_cnt_q <= fpu_cnt_d;
    end
endmodule
